mul_seq: RTL and testbench
==========================

Name: mul_seq

Overview:
- Parametrised iterative multiply sequencer for the single-cycle core. It replaces the fixed 32-bit ucode multiply expansion.
- When decode flags a multiply, the block accepts both operands and runs a radix-2 shift-add over WIDTH cycles, holding fetch while it runs.
- On completion it returns the product, the write-back register index and merged flags to execute/regfile.
- It supports four modes: unsigned or signed, each selecting the low or high half of the product.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥4.
- REG_ADDR_W, 4, register index width.
- CNT_W, $clog2(WIDTH), iteration counter width.

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request; sampled only in IDLE.
- mul_type  input  2  00 unsigned-low, 01 unsigned-high, 10 signed-low, 11 signed-high.
- set_flags  input  1  update flags on completion.
- dest_reg  input  REG_ADDR_W  destination register index.
- op_a  input  WIDTH  multiplicand.
- op_b  input  WIDTH  multiplier.
- flags_in  input  4  current {N,Z,C,V}.
- flush  input  1  abort in-flight operation.
- busy  output  1  high in RUN and DONE.
- hold_fetch  output  1  equals busy; drives the fetch/ucode mux and PC hold.
- done  output  1  one-cycle completion pulse.
- write_en  output  1  regfile write strobe; equals done.
- result  output  WIDTH  selected product half.
- result_reg  output  REG_ADDR_W  captured dest_reg.
- flags_out  output  4  merged {N,Z,C,V}.
- flags_valid  output  1  equals done.

Behaviour:
- **Reset.** Asynchronous on rst=1. State=IDLE; all outputs 0, including result, result_reg and flags_out. Internal accumulator and counter are cleared. Reset mid-RUN abandons the operation with no done/write_en pulse.
- **States.**
  - IDLE: start=1 at an edge captures op_a, op_b, mul_type, set_flags, dest_reg and flags_in. It loads counter=WIDTH-1 and moves to RUN.
  - RUN: one multiplier bit per cycle, LSB first. If the current multiplier bit is 1, add the multiplicand magnitude into the 2*WIDTH accumulator, then shift. When counter=0, go to DONE; otherwise decrement.
  - DONE: done=write_en=flags_valid=1 for exactly one cycle, then IDLE.
- **Latency.**
  - Start accepted at edge E0; RUN occupies edges E1..E(WIDTH).
  - done is high during the cycle after edge E(WIDTH), i.e. WIDTH+1 cycles after E0.
  - The next start can be accepted at the edge ending DONE's cycle+1: IDLE is required, so there is 1 idle cycle minimum between ops.
- **Ignored starts.** start while busy is ignored; no queueing.
- **Signed modes.**
  - Magnitudes of op_a/op_b are captured at start; the 2*WIDTH product is negated in DONE if the sign bits differ.
  - The most-negative operand is handled: magnitude 2^(WIDTH-1) in WIDTH+1-bit arithmetic.
- **Result selection.** Low modes output product[WIDTH-1:0]; high modes output product[2*WIDTH-1:WIDTH].
- **Output holding.** result/result_reg/flags_out hold their last values after DONE until the next DONE or reset.
- **Flags, set_flags=0.** flags_out = captured flags_in.
- **Flags, set_flags=1.**
  - N = result[WIDTH-1]; Z = (result==0).
  - Unsigned-low: C=V=(product high half ≠0).
  - Signed-low: C=V=(high half ≠ sign-extension of result[WIDTH-1]).
  - High modes: C, V preserved from captured flags_in.
- **Flush.**
  - flush=1 in RUN or DONE returns to IDLE at the next edge; done/write_en are suppressed. If asserted during DONE, the done pulse in that cycle is masked combinationally.
  - flush in IDLE has no effect; flush has priority over start in the same cycle.
- **Counter wrap.** Counter never wraps; it stops at 0.

Test Plan:
- Unsigned-low (WIDTH=32): op_a=7, op_b=6, set_flags=1, flags_in=4'b0011 → done at E0+33, result=42, write_en=1, flags_out=4'b0000.
- Unsigned-high: op_a=op_b=32'hFFFF_FFFF → result=32'hFFFF_FFFE.
  - Rerun in unsigned-low → result=32'h0000_0001, C=V=1.
- Signed-low: op_a=-3 (32'hFFFF_FFFD), op_b=5 → result=32'hFFFF_FFF1, flags_out N=1,Z=0,C=0,V=0.
  - Signed-high, op_a=op_b=32'h8000_0000 → result=32'h4000_0000.
- Handshake: start held high continuously → ops accepted every WIDTH+2 cycles; busy/hold_fetch high exactly WIDTH+1 cycles per op; start during RUN is ignored (captured operands unchanged).
- Abort: flush at E0+10 → IDLE next edge, no done/write_en.
  - rst at E0+20 → all outputs 0 asynchronously, no pulse.
  - Next start completes normally.
- Parameter sweep: WIDTH=8, REG_ADDR_W=5, dest_reg=5'd17, op_a=8'd200, op_b=8'd3, unsigned-low → done at E0+9, result=8'd88, result_reg=17, C=V=1.

Source files
------------

// File: rtl/mul_seq.sv
// ---------------------------------------------------------------------------
// mul_seq: iterative radix-2 shift-add multiply sequencer for the
// single-cycle core. It takes both operands when decode asks for a multiply,
// works through one multiplier bit per cycle for WIDTH cycles while holding
// fetch, then returns the product, its write-back index and merged flags.
//
// Ports:
//   clk, rst      core clock, asynchronous active-high reset
//   start         multiply request, only looked at while idle
//   mul_type      00 unsigned-low, 01 unsigned-high, 10 signed-low,
//                 11 signed-high
//   set_flags     update N/Z/C/V from the product on completion
//   dest_reg      write-back register index
//   op_a, op_b    multiplicand and multiplier
//   flags_in      current {N,Z,C,V}
//   flush         abort the operation in flight
//   busy          high while running or completing
//   hold_fetch    same as busy; holds PC and selects the ucode mux
//   done          one-cycle completion pulse
//   write_en      regfile write strobe, same as done
//   result        selected product half, held until the next completion
//   result_reg    captured dest_reg, held alongside result
//   flags_out     merged {N,Z,C,V}, held alongside result
//   flags_valid   same as done
// ---------------------------------------------------------------------------
module mul_seq #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = $clog2(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            mul_type,
  input  logic                  set_flags,
  input  logic [REG_ADDR_W-1:0] dest_reg,
  input  logic [WIDTH-1:0]      op_a,
  input  logic [WIDTH-1:0]      op_b,
  input  logic [3:0]            flags_in,
  input  logic                  flush,
  output logic                  busy,
  output logic                  hold_fetch,
  output logic                  done,
  output logic                  write_en,
  output logic [WIDTH-1:0]      result,
  output logic [REG_ADDR_W-1:0] result_reg,
  output logic [3:0]            flags_out,
  output logic                  flags_valid
);

  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } MulState;

  MulState curState, nextState;

  logic [CNT_W-1:0]      count;
  logic [WIDTH-1:0]      mcand;
  logic [PW-1:0]         acc;
  logic                  negateCap;
  logic                  setFlagsCap;
  logic [1:0]            modeCap;
  logic [3:0]            flagsCap;
  logic [REG_ADDR_W-1:0] destCap;

  logic [WIDTH-1:0]      resultQ;
  logic [REG_ADDR_W-1:0] resultRegQ;
  logic [3:0]            flagsQ;

  logic                  acceptStart;
  logic                  lastStep;
  logic                  aNeg, bNeg;
  logic [WIDTH-1:0]      magA, magB;
  logic [WIDTH:0]        sumHi;
  logic [PW-1:0]         accStep;
  logic [PW-1:0]         product;
  logic [WIDTH-1:0]      lowHalf, highHalf, selResult;
  logic                  overflow;
  logic [3:0]            newFlags;

  // A request is taken only from IDLE, and a same-cycle flush wins over it.
  // lastStep marks the edge that folds in the final multiplier bit.
  assign acceptStart = (curState == IDLE) && start && !flush;
  assign lastStep    = (curState == RUN) && (count == '0) && !flush;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      curState <= IDLE;
    end else begin
      curState <= nextState;
    end
  end

  // Next-state logic: IDLE -> RUN on an accepted start, RUN -> DONE once the
  // counter has reached zero, DONE always falls back to IDLE. Flush from RUN
  // abandons the operation; from DONE it ends up in IDLE as well.
  always_comb begin
    nextState = curState;
    unique case (curState)
      IDLE: if (acceptStart) nextState = RUN;
      RUN: begin
        if (flush)              nextState = IDLE;
        else if (count == '0)   nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Operand magnitudes and one shift-add step. Operands are multiplied as
  // unsigned magnitudes; the most-negative value maps to 2^(WIDTH-1), which
  // still fits in WIDTH unsigned bits. The accumulator keeps the partial
  // product in its upper half and the unconsumed multiplier bits in its lower
  // half, so each step adds into the top and shifts everything right by one.
  always_comb begin
    aNeg     = mul_type[1] & op_a[WIDTH-1];
    bNeg     = mul_type[1] & op_b[WIDTH-1];
    magA     = aNeg ? (~op_a + WIDTH'(1)) : op_a;
    magB     = bNeg ? (~op_b + WIDTH'(1)) : op_b;
    sumHi    = {1'b0, acc[PW-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    accStep  = {sumHi, acc[WIDTH-1:1]};
    product  = negateCap ? (~accStep + PW'(1)) : accStep;
    lowHalf  = product[WIDTH-1:0];
    highHalf = product[PW-1:WIDTH];
  end

  // Result selection and flag merge. Low modes report whether the discarded
  // high half carried information: for unsigned any set bit, for signed
  // anything other than the sign extension of the low half. High modes keep
  // the incoming C/V.
  always_comb begin
    selResult = modeCap[0] ? highHalf : lowHalf;
    overflow  = modeCap[1] ? (highHalf != {WIDTH{lowHalf[WIDTH-1]}})
                           : (highHalf != '0);
    newFlags  = flagsCap;
    if (setFlagsCap) begin
      newFlags[3] = selResult[WIDTH-1];
      newFlags[2] = (selResult == '0);
      if (!modeCap[0]) begin
        newFlags[1] = overflow;
        newFlags[0] = overflow;
      end
    end
  end

  // Operand capture and the iteration datapath. The counter stops at zero
  // rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= '0;
      mcand       <= '0;
      acc         <= '0;
      negateCap   <= 1'b0;
      setFlagsCap <= 1'b0;
      modeCap     <= 2'b00;
      flagsCap    <= 4'b0000;
      destCap     <= '0;
    end else if (acceptStart) begin
      count       <= CNT_W'(WIDTH - 1);
      mcand       <= magA;
      acc         <= {{WIDTH{1'b0}}, magB};
      negateCap   <= aNeg ^ bNeg;
      setFlagsCap <= set_flags;
      modeCap     <= mul_type;
      flagsCap    <= flags_in;
      destCap     <= dest_reg;
    end else if (curState == RUN) begin
      acc <= accStep;
      if (count != '0) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Visible results are loaded on the edge entering DONE and then held until
  // the next completion, so execute/regfile see stable values during DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resultQ    <= '0;
      resultRegQ <= '0;
      flagsQ     <= 4'b0000;
    end else if (lastStep) begin
      resultQ    <= selResult;
      resultRegQ <= destCap;
      flagsQ     <= newFlags;
    end
  end

  // A flush arriving during DONE masks that cycle's pulse combinationally.
  assign busy        = (curState != IDLE);
  assign hold_fetch  = busy;
  assign done        = (curState == DONE) && !flush;
  assign write_en    = done;
  assign flags_valid = done;
  assign result      = resultQ;
  assign result_reg  = resultRegQ;
  assign flags_out   = flagsQ;

endmodule

// File: tb/tb_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_mul_seq: self-checking bench for mul_seq. A 32-bit and an 8-bit instance
// share one set of stimulus signals; useNarrow picks which one receives start
// and whose outputs are observed. Expected values come from a plain
// arithmetic reference model of the multiply and flag rules.
// ---------------------------------------------------------------------------
module tb_mul_seq;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, flush, setFlags, useNarrow;
  logic [1:0]  mulType;
  logic [4:0]  destReg;
  logic [31:0] opA, opB;
  logic [3:0]  flagsIn;

  logic        busy32, hold32, done32, we32, fv32;
  logic [31:0] res32;
  logic [3:0]  rreg32;
  logic [3:0]  fo32;
  logic        busy8, hold8, done8, we8, fv8;
  logic [7:0]  res8;
  logic [4:0]  rreg8;
  logic [3:0]  fo8;

  logic        obsBusy, obsHold, obsDone, obsWe, obsFv;
  logic [31:0] obsResult;
  logic [4:0]  obsReg;
  logic [3:0]  obsFlags;

  int          checkCount = 0;
  int          passCount  = 0;
  logic [31:0] lastRes;

  always #5 clk = ~clk;

  mul_seq #(.WIDTH(32), .REG_ADDR_W(4)) dut32 (
    .clk(clk), .rst(rst), .start(start && !useNarrow), .mul_type(mulType),
    .set_flags(setFlags), .dest_reg(destReg[3:0]), .op_a(opA), .op_b(opB),
    .flags_in(flagsIn), .flush(flush), .busy(busy32), .hold_fetch(hold32),
    .done(done32), .write_en(we32), .result(res32), .result_reg(rreg32),
    .flags_out(fo32), .flags_valid(fv32)
  );

  mul_seq #(.WIDTH(8), .REG_ADDR_W(5)) dut8 (
    .clk(clk), .rst(rst), .start(start && useNarrow), .mul_type(mulType),
    .set_flags(setFlags), .dest_reg(destReg), .op_a(opA[7:0]), .op_b(opB[7:0]),
    .flags_in(flagsIn), .flush(flush), .busy(busy8), .hold_fetch(hold8),
    .done(done8), .write_en(we8), .result(res8), .result_reg(rreg8),
    .flags_out(fo8), .flags_valid(fv8)
  );

  assign obsBusy   = useNarrow ? busy8 : busy32;
  assign obsHold   = useNarrow ? hold8 : hold32;
  assign obsDone   = useNarrow ? done8 : done32;
  assign obsWe     = useNarrow ? we8   : we32;
  assign obsFv     = useNarrow ? fv8   : fv32;
  assign obsResult = useNarrow ? {24'b0, res8} : res32;
  assign obsReg    = useNarrow ? rreg8 : {1'b0, rreg32};
  assign obsFlags  = useNarrow ? fo8   : fo32;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: true integer product of w-bit operands, then the
  // requested half and the flag rules expressed as range tests.
  function automatic void refModel(input int w, input logic [1:0] t,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic sf, input logic [3:0] fin,
                                   output logic [31:0] res,
                                   output logic [3:0] fo);
    logic [63:0] mask, p, hi64;
    longint      sa, sb, ps;
    logic        ovf;
    mask = (64'd1 << w) - 64'd1;
    if (t[1]) begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
      if (a[w-1]) sa = sa - (longint'(1) << w);
      if (b[w-1]) sb = sb - (longint'(1) << w);
      ps  = sa * sb;
      p   = ps;
      ovf = (ps < -(longint'(1) << (w-1))) || (ps > (longint'(1) << (w-1)) - 1);
    end else begin
      p   = {32'b0, a} * {32'b0, b};
      ovf = (p > mask);
    end
    hi64 = (p >> w) & mask;
    res  = t[0] ? hi64[31:0] : (p[31:0] & mask[31:0]);
    fo   = fin;
    if (sf) begin
      fo[3] = res[w-1];
      fo[2] = (res == 32'd0);
      if (!t[0]) fo[1:0] = {ovf, ovf};
    end
  endfunction

  // One full operation on the selected instance: drive, scramble inputs
  // after acceptance, wait (bounded) for done and check everything returned.
  task automatic applyStimulus(input logic [1:0] t, input logic [31:0] a,
                               input logic [31:0] b, input logic sf,
                               input logic [3:0] fin, input logic [4:0] dst);
    int          w;
    int          lat;
    logic        got;
    logic [31:0] expRes;
    logic [3:0]  expFlags;
    w = useNarrow ? 8 : 32;
    if (useNarrow) begin
      a = a & 32'hFF;
      b = b & 32'hFF;
    end else begin
      dst = dst & 5'hF;
    end
    refModel(w, t, a, b, sf, fin, expRes, expFlags);
    mulType = t; opA = a; opB = b; setFlags = sf; flagsIn = fin;
    destReg = dst; start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    opA = $urandom; opB = $urandom; flagsIn = 4'($urandom);
    destReg = 5'($urandom); mulType = 2'($urandom); setFlags = 1'($urandom);
    lat = 0;
    got = 1'b0;
    while (lat < w + 4 && !got) begin
      @(posedge clk) #1;
      lat++;
      if (obsDone) got = 1'b1;
    end
    checkOutput("latency", lat, w);
    checkOutput("result", obsResult, expRes);
    checkOutput("resultReg", obsReg, dst);
    checkOutput("flags", obsFlags, expFlags);
    checkOutput("writeEn", obsWe, 1);
    checkOutput("flagsValid", obsFv, 1);
    checkOutput("holdInDone", obsHold, 1);
    @(posedge clk) #1;
    checkOutput("donePulseWidth", obsDone, 0);
    checkOutput("idleAfterDone", obsBusy, 0);
    checkOutput("resultHeld", obsResult, expRes);
    lastRes = expRes;
  endtask

  // Random operand with a bias toward the interesting corner values.
  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'h0000_0000;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Start held high: back-to-back ops, start during RUN must be ignored.
  task automatic handshakeTest();
    logic [31:0] a1, b1, a2, b2, exp1, exp2;
    logic [3:0]  fDummy;
    int          nDone, runLen, nRuns, firstDone, guard;
    a1 = $urandom | 32'h1; b1 = $urandom | 32'h1;
    a2 = a1 ^ 32'h5A5A_0F0F; b2 = b1 + 32'd77;
    refModel(W, 2'b00, a1, b1, 1'b0, 4'b0000, exp1, fDummy);
    refModel(W, 2'b00, a2, b2, 1'b0, 4'b0000, exp2, fDummy);
    mulType = 2'b00; setFlags = 1'b0; flagsIn = 4'b0000; destReg = 5'd2;
    opA = a1; opB = b1; start = 1'b1;
    @(posedge clk) #1;
    opA = a2; opB = b2;
    nDone = 0; runLen = 1; nRuns = 0; firstDone = 0;
    for (int k = 1; k <= 2 * W + 4; k++) begin
      @(posedge clk) #1;
      if (obsDone) begin
        if (nDone == 0) begin
          checkOutput("hsResult0", obsResult, exp1);
          firstDone = k;
        end else if (nDone == 1) begin
          checkOutput("hsResult1", obsResult, exp2);
          checkOutput("hsSpacing", k - firstDone, W + 2);
        end
        nDone++;
      end
      if (obsHold) runLen++;
      else if (runLen != 0) begin
        checkOutput("hsBusyLen", runLen, W + 1);
        nRuns++;
        runLen = 0;
      end
    end
    checkOutput("hsDoneCount", nDone, 2);
    checkOutput("hsRunCount", nRuns, 2);
    start = 1'b0;
    guard = 0;
    while (obsBusy && guard < 3 * W) begin
      @(posedge clk) #1;
      guard++;
    end
    checkOutput("hsDrainIdle", obsBusy, 0);
  endtask

  // Flush ten edges into an operation: idle next edge, no pulse, result kept.
  task automatic abortTest();
    int seen;
    mulType = 2'b00; opA = 32'd1234; opB = 32'd999; setFlags = 1'b1;
    start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk) #1;
    flush = 1'b0;
    checkOutput("flushIdle", obsBusy, 0);
    checkOutput("flushNoDone", obsDone, 0);
    seen = 0;
    repeat (W + 4) begin
      @(posedge clk) #1;
      if (obsDone || obsWe) seen++;
    end
    checkOutput("flushNoPulse", seen, 0);
    checkOutput("flushResultKept", obsResult, lastRes);
  endtask

  // Reset twenty edges into an operation clears outputs immediately.
  task automatic resetTest();
    int seen;
    mulType = 2'b10; opA = 32'hFFFF_FF00; opB = 32'd3; setFlags = 1'b1;
    start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstBusy", obsBusy, 0);
    checkOutput("rstDone", obsDone, 0);
    checkOutput("rstResult", obsResult, 0);
    checkOutput("rstReg", obsReg, 0);
    checkOutput("rstFlags", obsFlags, 0);
    rst = 1'b0;
    seen = 0;
    repeat (W + 4) begin
      @(posedge clk) #1;
      if (obsDone || obsWe || obsBusy) seen++;
    end
    checkOutput("rstNoPulse", seen, 0);
  endtask

  // Main sequence.
  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; setFlags = 1'b0;
    useNarrow = 1'b0; mulType = 2'b00; destReg = '0;
    opA = '0; opB = '0; flagsIn = '0; lastRes = '0;
    #3;
    checkOutput("resetBusy", obsBusy, 0);
    checkOutput("resetHold", obsHold, 0);
    checkOutput("resetDone", obsDone, 0);
    checkOutput("resetResult", obsResult, 0);
    checkOutput("resetFlags", obsFlags, 0);
    #9 rst = 1'b0;

    applyStimulus(2'b00, 32'd7, 32'd6, 1'b1, 4'b0011, 5'd3);
    checkOutput("plan42", obsResult, 42);
    checkOutput("plan42Flags", obsFlags, 4'b0000);
    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'b0000, 5'd4);
    checkOutput("planHighFF", obsResult, 32'hFFFF_FFFE);
    applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'b0000, 5'd5);
    checkOutput("planLowFFCV", obsFlags[1:0], 2'b11);
    applyStimulus(2'b10, 32'hFFFF_FFFD, 32'd5, 1'b1, 4'b0000, 5'd6);
    checkOutput("planSignedLow", obsResult, 32'hFFFF_FFF1);
    checkOutput("planSignedFlags", obsFlags, 4'b1000);
    applyStimulus(2'b11, 32'h8000_0000, 32'h8000_0000, 1'b0, 4'b1010, 5'd7);
    checkOutput("planMostNeg", obsResult, 32'h4000_0000);

    repeat (16) begin
      applyStimulus(2'($urandom_range(0, 3)), pickOperand(), pickOperand(),
                    1'($urandom), 4'($urandom), 5'($urandom));
    end

    handshakeTest();
    applyStimulus(2'b00, 32'd7, 32'd6, 1'b0, 4'b0101, 5'd9);
    abortTest();
    resetTest();
    applyStimulus(2'b10, 32'hFFFF_FF00, 32'd3, 1'b1, 4'b0000, 5'd11);

    useNarrow = 1'b1;
    applyStimulus(2'b00, 32'd200, 32'd3, 1'b1, 4'b0000, 5'd17);
    checkOutput("plan88", obsResult, 88);
    checkOutput("plan88Reg", obsReg, 17);
    checkOutput("plan88Flags", obsFlags, 4'b0011);
    repeat (8) begin
      applyStimulus(2'($urandom_range(0, 3)), pickOperand(), pickOperand(),
                    1'($urandom), 4'($urandom), 5'($urandom));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
